load_align_pipe: RTL and testbench

Parametrised, pipelined successor to the W-stage load extender. It accepts one load result per cycle from the memory stage via a valid/ready handshake. It aligns and sign/zero-extends byte, half, word and (64-bit builds) doubleword loads, and merges unaligned-left and unaligned-right loads (LWL/LWR family) with the old register value. It flags misaligned accesses and queues results in a DEPTH-entry output buffer in front of register writeback.

---
 rtl/load_align_pipe_pkg.sv | 23 ++
 rtl/load_align_pipe_format.sv | 71 +++++++
 rtl/load_align_pipe.sv | 97 +++++++++
 tb/tb_load_align_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/load_align_pipe_pkg.sv
// Shared size/mode encodings and small helpers for the load alignment pipeline.
package load_align_pipe_pkg;

  localparam logic [1:0] BE_BYTE  = 2'b00;
  localparam logic [1:0] BE_HALF  = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b10;
  localparam logic [1:0] BE_DWORD = 2'b11;

  localparam logic [1:0] LD_NORMAL = 2'b00;
  localparam logic [1:0] LD_LEFT   = 2'b01;
  localparam logic [1:0] LD_RIGHT  = 2'b10;

  localparam logic LOAD_EXT_SIGNED = 1'b1;

  function automatic logic [6:0] size_bits(input logic [1:0] size);
    return 7'd8 << size;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_align_pipe_format.sv
// Combinational load formatter: alignment, sign/zero extension, left/right merge and adel.
module load_format
  import load_align_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W-1:0]          in_old,
  input  logic [$clog2(DATA_W/8)-1:0] in_addr,
  input  logic [1:0]                 in_size,
  input  logic                       in_signed,
  input  logic [1:0]                 in_mode,
  output logic [DATA_W-1:0]          fmt_data,
  output logic                       fmt_adel
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONES = '1;

  logic [SH_W-1:0]   shift_r;
  logic [SH_W-1:0]   shift_l;
  logic [DATA_W-1:0] field;
  logic [OFF_W-1:0]  align_mask;
  logic [6:0]        bits;
  logic              misaligned;

  // Keep the low `bits` bits of value and fill the rest with zeros or the sign bit.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] value,
                                               input logic [6:0] width, input logic sgn);
    logic [DATA_W-1:0] mask;
    logic [SH_W-1:0]   top;
    if (int'(width) >= DATA_W) return value;
    mask = ~(ONES << width);
    top  = SH_W'(width - 7'd1);
    if (sgn && value[top]) return value | ~mask;
    return value & mask;
  endfunction

  assign shift_r    = {in_addr, 3'b000};
  assign shift_l    = {~in_addr, 3'b000};
  assign field      = in_data >> shift_r;
  assign bits       = size_bits(in_size);
  assign align_mask = OFF_W'(size_bytes(in_size) - 4'd1);
  assign misaligned = ((in_addr & align_mask) != '0) || (int'(bits) > DATA_W);

  always_comb begin
    fmt_data = '0;
    fmt_adel = 1'b0;
    case (in_mode)
      LD_LEFT: begin
        fmt_data = (in_data << shift_l) | (in_old & ~(ONES << shift_l));
      end
      LD_RIGHT: begin
        fmt_data = field | (in_old & ~(ONES >> shift_r));
        // LWR of a full word on a 64-bit datapath yields a sign-extended word.
        if (DATA_W == 64 && in_size == BE_WORD && in_addr == '0)
          fmt_data = extend(fmt_data, 7'd32, LOAD_EXT_SIGNED);
      end
      default: begin
        if (misaligned) begin
          fmt_adel = 1'b1;
        end else begin
          fmt_data = extend(field, bits, in_signed);
        end
      end
    endcase
  end

endmodule

// File: rtl/load_align_pipe.sv
// Load result formatter followed by a DEPTH-entry FIFO feeding register writeback.
module load_align_pipe
  import load_align_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [DATA_W-1:0]           in_old,
  input  logic [$clog2(DATA_W/8)-1:0] in_addr,
  input  logic [1:0]                  in_size,
  input  logic                        in_signed,
  input  logic [1:0]                  in_mode,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_adel
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic              mem_adel [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] fmt_data;
  logic              fmt_adel;
  logic              push;
  logic              pop;

  load_format #(.DATA_W(DATA_W)) u_format (
    .in_data   (in_data),
    .in_old    (in_old),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_mode   (in_mode),
    .fmt_data  (fmt_data),
    .fmt_adel  (fmt_adel)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = ~reset & ~flush & (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_tag  = out_valid ? mem_tag[rd_ptr]  : '0;
  assign out_adel = out_valid ? mem_adel[rd_ptr] : 1'b0;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
        mem_adel[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= fmt_data;
        mem_tag[wr_ptr]  <= in_tag;
        mem_adel[wr_ptr] <= fmt_adel;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_load_align_pipe.sv
// Directed bench for load_align_pipe: 32- and 64-bit formatting plus FIFO, flush and reset behaviour.
module tb_load_align_pipe;
  import load_align_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        out_ready;
  logic [63:0] in_data;
  logic [63:0] in_old;
  logic [2:0]  in_addr;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        in_valid32, in_valid64;

  logic        in_ready32, out_valid32, out_adel32;
  logic [31:0] out_data32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_adel64;
  logic [63:0] out_data64;
  logic [4:0]  out_tag64;

  int check_count = 0;
  int fail_count  = 0;

  always #5 clk = ~clk;

  load_align_pipe #(.DATA_W(32), .TAG_W(5), .DEPTH(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data[31:0]), .in_old(in_old[31:0]), .in_addr(in_addr[1:0]),
    .in_size(in_size), .in_signed(in_signed), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_data(out_data32), .out_tag(out_tag32), .out_adel(out_adel32)
  );

  load_align_pipe #(.DATA_W(64), .TAG_W(5), .DEPTH(2)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data), .in_old(in_old), .in_addr(in_addr),
    .in_size(in_size), .in_signed(in_signed), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .out_tag(out_tag64), .out_adel(out_adel64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one beat for a single cycle; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit wide, input logic [63:0] data, input logic [63:0] old,
                               input logic [2:0] addr, input logic [1:0] size, input logic sgn,
                               input logic [1:0] mode, input logic [4:0] tag);
    @(negedge clk);
    in_data   = data;
    in_old    = old;
    in_addr   = addr;
    in_size   = size;
    in_signed = sgn;
    in_mode   = mode;
    in_tag    = tag;
    if (wide) in_valid64 = 1'b1;
    else      in_valid32 = 1'b1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
  endtask

  task automatic runFormat(input string name, input bit wide, input logic [63:0] data,
                           input logic [63:0] old, input logic [2:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [1:0] mode, input logic [4:0] tag,
                           input logic [63:0] exp_data, input logic exp_adel);
    applyStimulus(wide, data, old, addr, size, sgn, mode, tag);
    checkOutput({name, " valid"}, wide ? out_valid64 : out_valid32, 64'd1);
    checkOutput({name, " data"}, wide ? out_data64 : {32'h0, out_data32}, exp_data);
    checkOutput({name, " adel"}, wide ? out_adel64 : out_adel32, exp_adel);
    checkOutput({name, " tag"}, wide ? out_tag64 : out_tag32, tag);
    @(posedge clk);
    #1;
    checkOutput({name, " drained"}, wide ? out_valid64 : out_valid32, 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    in_data = '0; in_old = '0; in_addr = '0; in_size = '0;
    in_signed = 1'b0; in_mode = '0; in_tag = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready32, 64'd0);
    checkOutput("reset out_valid", out_valid32, 64'd0);
    checkOutput("reset out_data", out_data64, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post-reset in_ready32", in_ready32, 64'd1);
    checkOutput("post-reset in_ready64", in_ready64, 64'd1);

    // 32-bit formatting, in_data = 0x8899AABB
    runFormat("lb a1",  0, 64'h8899AABB, 64'h0, 3'd1, BE_BYTE, 1'b1, LD_NORMAL, 5'd1, 64'hFFFFFFAA, 1'b0);
    runFormat("lbu a3", 0, 64'h8899AABB, 64'h0, 3'd3, BE_BYTE, 1'b0, LD_NORMAL, 5'd2, 64'h00000088, 1'b0);
    runFormat("lh a2",  0, 64'h8899AABB, 64'h0, 3'd2, BE_HALF, 1'b1, LD_NORMAL, 5'd3, 64'hFFFF8899, 1'b0);
    runFormat("lh a1",  0, 64'h8899AABB, 64'h0, 3'd1, BE_HALF, 1'b1, LD_NORMAL, 5'd4, 64'h0, 1'b1);
    runFormat("lhu a0", 0, 64'h8899AABB, 64'h0, 3'd0, BE_HALF, 1'b0, LD_NORMAL, 5'd5, 64'h0000AABB, 1'b0);
    runFormat("lw a0",  0, 64'h8899AABB, 64'h0, 3'd0, BE_WORD, 1'b1, LD_NORMAL, 5'd6, 64'h8899AABB, 1'b0);
    runFormat("lw a2",  0, 64'h8899AABB, 64'h0, 3'd2, BE_WORD, 1'b1, LD_NORMAL, 5'd7, 64'h0, 1'b1);
    runFormat("ld 32b", 0, 64'h8899AABB, 64'h0, 3'd0, BE_DWORD, 1'b0, LD_NORMAL, 5'd8, 64'h0, 1'b1);
    runFormat("rsv a0", 0, 64'h8899AABB, 64'h0, 3'd0, BE_BYTE, 1'b0, 2'b11, 5'd9, 64'h000000BB, 1'b0);
    runFormat("left a1",  0, 64'h8899AABB, 64'h11223344, 3'd1, BE_HALF, 1'b1, LD_LEFT,  5'd10, 64'hAABB3344, 1'b0);
    runFormat("right a1", 0, 64'h8899AABB, 64'h11223344, 3'd1, BE_HALF, 1'b1, LD_RIGHT, 5'd11, 64'h118899AA, 1'b0);
    runFormat("left a3",  0, 64'h8899AABB, 64'h11223344, 3'd3, BE_WORD, 1'b0, LD_LEFT,  5'd12, 64'h8899AABB, 1'b0);
    runFormat("right a0", 0, 64'h8899AABB, 64'h11223344, 3'd0, BE_WORD, 1'b0, LD_RIGHT, 5'd13, 64'h8899AABB, 1'b0);

    // 64-bit formatting
    runFormat("w64 lw a4",  1, 64'h80000000_00000001, 64'h0, 3'd4, BE_WORD,  1'b1, LD_NORMAL, 5'd14, 64'hFFFFFFFF_80000000, 1'b0);
    runFormat("w64 lwu a4", 1, 64'h80000000_00000001, 64'h0, 3'd4, BE_WORD,  1'b0, LD_NORMAL, 5'd15, 64'h00000000_80000000, 1'b0);
    runFormat("w64 ld a0",  1, 64'h80000000_00000001, 64'h0, 3'd0, BE_DWORD, 1'b0, LD_NORMAL, 5'd16, 64'h80000000_00000001, 1'b0);
    runFormat("w64 ld a4",  1, 64'h80000000_00000001, 64'h0, 3'd4, BE_DWORD, 1'b0, LD_NORMAL, 5'd17, 64'h0, 1'b1);
    runFormat("w64 lwr a0", 1, 64'h12345678_9ABCDEF0, 64'h0, 3'd0, BE_WORD,  1'b0, LD_RIGHT,  5'd18, 64'hFFFFFFFF_9ABCDEF0, 1'b0);
    runFormat("w64 ldr a0", 1, 64'h12345678_9ABCDEF0, 64'h0, 3'd0, BE_BYTE,  1'b0, LD_RIGHT,  5'd19, 64'h12345678_9ABCDEF0, 1'b0);
    runFormat("w64 left a5", 1, 64'h12345678_9ABCDEF0, 64'h11111111_22222222, 3'd5, BE_BYTE, 1'b0, LD_LEFT, 5'd20,
              64'h56789ABC_DEF02222, 1'b0);

    // FIFO fill with the consumer stalled, then in-order drain
    @(negedge clk);
    out_ready  = 1'b0;
    in_size    = BE_WORD; in_addr = 3'd0; in_mode = LD_NORMAL;
    in_valid32 = 1'b1; in_tag = 5'd1;
    @(posedge clk); #1;
    checkOutput("fifo head after 1", out_tag32, 64'd1);
    checkOutput("fifo ready after 1", in_ready32, 64'd1);
    @(negedge clk); in_tag = 5'd2;
    @(posedge clk); #1;
    checkOutput("fifo full ready", in_ready32, 64'd0);
    checkOutput("fifo head after 2", out_tag32, 64'd1);
    @(negedge clk); in_tag = 5'd3;
    @(posedge clk); #1;
    checkOutput("fifo still full", in_ready32, 64'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("fifo pop 1 head", out_tag32, 64'd2);
    checkOutput("fifo ready after pop", in_ready32, 64'd1);
    @(posedge clk); #1;
    checkOutput("fifo pop 2 head", out_tag32, 64'd3);
    checkOutput("fifo valid tag3", out_valid32, 64'd1);
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    checkOutput("fifo empty", out_valid32, 64'd0);
    checkOutput("fifo empty tag", out_tag32, 64'd0);

    // Flush with two entries buffered and a beat offered in the same cycle
    @(negedge clk);
    out_ready = 1'b0; in_valid32 = 1'b1; in_tag = 5'd4;
    @(negedge clk); in_tag = 5'd5;
    @(negedge clk);
    checkOutput("pre-flush valid", out_valid32, 64'd1);
    flush = 1'b1; in_tag = 5'd6;
    #1;
    checkOutput("flush ready low", in_ready32, 64'd0);
    @(posedge clk); #1;
    checkOutput("flush out_valid", out_valid32, 64'd0);
    checkOutput("flush out_tag", out_tag32, 64'd0);
    flush = 1'b0; in_valid32 = 1'b0;
    @(posedge clk); #1;
    checkOutput("flush input dropped", out_valid32, 64'd0);
    checkOutput("flush ready back", in_ready32, 64'd1);

    // Asynchronous reset mid-stream with one entry held
    applyStimulus(0, 64'h8899AABB, 64'h0, 3'd0, BE_WORD, 1'b0, LD_NORMAL, 5'd7);
    checkOutput("pre-reset valid", out_valid32, 64'd1);
    checkOutput("pre-reset data", out_data32, 64'h8899AABB);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset valid", out_valid32, 64'd0);
    checkOutput("async reset data", out_data32, 64'd0);
    checkOutput("async reset tag", out_tag32, 64'd0);
    checkOutput("async reset ready", in_ready32, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("release ready", in_ready32, 64'd1);
    checkOutput("release valid", out_valid32, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
